// File: rtl/triangle_frame_buffer.sv
// triangle_frame_buffer: ping-pong capture of projected triangles, replayed once
// per video frame to the rasterizer over a valid/ready port.
// Optional feature macro: TRIBUF_DROP_COUNT_EN (saturating count of dropped triangles).
module triangle_frame_buffer #(
  parameter int DEPTH = 512
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] triangle,
  input  logic         triangle_valid,
  input  logic         done_in,
  input  logic         new_frame,
  output logic [127:0] tri_out,
  output logic         tri_out_valid,
  input  logic         tri_out_ready,
  output logic         replay_done,
  output logic [15:0]  drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic       {W_FILL, W_CLOSED} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_PRESENT} rstate_e;

  // Both banks live in one array; the bank select is the top address bit.
  logic [127:0] mem [2*DEPTH];

  wstate_e       wst_q, wst_d;
  rstate_e       rd_st_q, rd_st_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_len_q, rd_len_d;
  logic [PW-1:0] rd_idx_q, rd_idx_d;
  logic          wr_bank_q, wr_bank_d;
  logic          has_frame_q, has_frame_d;
  logic          done_prev_q;
  logic          tri_vld_q, tri_vld_d;
  logic          rdone_q, rdone_d;
  logic [127:0]  tri_out_q;
  logic          wr_en, rd_en, swap, done_rise;

  // Write side: fill the write bank, close on done rising edge, swap once reader is idle.
  always_comb begin
    wst_d       = wst_q;
    wr_ptr_d    = wr_ptr_q;
    wr_bank_d   = wr_bank_q;
    rd_len_d    = rd_len_q;
    has_frame_d = has_frame_q;
    wr_en       = 1'b0;
    swap        = 1'b0;
    done_rise   = done_in & ~done_prev_q;
    case (wst_q)
      W_FILL: begin
        // A triangle arriving with the closing edge is still stored.
        if (triangle_valid && (wr_ptr_q < PW'(DEPTH))) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (done_rise) wst_d = W_CLOSED;
      end
      W_CLOSED: begin
        if (rd_st_q == R_IDLE) begin
          swap        = 1'b1;
          wr_bank_d   = ~wr_bank_q;
          rd_len_d    = wr_ptr_q;
          wr_ptr_d    = '0;
          has_frame_d = 1'b1;
          wst_d       = W_FILL;
        end
      end
      default: wst_d = W_FILL;
    endcase
  end

  // Read side: replay rd_bank one triangle per fetch/present pair.
  // A swap in the same cycle as new_frame is visible to the replay it starts.
  always_comb begin
    rd_st_d   = rd_st_q;
    rd_idx_d  = rd_idx_q;
    tri_vld_d = tri_vld_q;
    rdone_d   = 1'b0;
    rd_en     = 1'b0;
    case (rd_st_q)
      R_IDLE: begin
        if (new_frame && (has_frame_q || swap)) begin
          rd_idx_d = '0;
          if (rd_len_d == '0) rdone_d = 1'b1;
          else                rd_st_d = R_FETCH;
        end
      end
      R_FETCH: begin
        rd_en     = 1'b1;
        tri_vld_d = 1'b1;
        rd_st_d   = R_PRESENT;
      end
      R_PRESENT: begin
        if (tri_out_ready) begin
          tri_vld_d = 1'b0;
          if (rd_idx_q == rd_len_q - 1'b1) begin
            rdone_d = 1'b1;
            rd_st_d = R_IDLE;
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
            rd_st_d  = R_FETCH;
          end
        end
      end
      default: rd_st_d = R_IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wst_q       <= W_FILL;
      rd_st_q     <= R_IDLE;
      wr_ptr_q    <= '0;
      rd_len_q    <= '0;
      rd_idx_q    <= '0;
      wr_bank_q   <= 1'b0;
      has_frame_q <= 1'b0;
      done_prev_q <= 1'b0;
      tri_vld_q   <= 1'b0;
      rdone_q     <= 1'b0;
    end else begin
      wst_q       <= wst_d;
      rd_st_q     <= rd_st_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_len_q    <= rd_len_d;
      rd_idx_q    <= rd_idx_d;
      wr_bank_q   <= wr_bank_d;
      has_frame_q <= has_frame_d;
      done_prev_q <= done_in;
      tri_vld_q   <= tri_vld_d;
      rdone_q     <= rdone_d;
    end
  end

  // Bank storage write port; no reset on the array itself.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank_q, wr_ptr_q[AW-1:0]}] <= triangle;
  end

  // Synchronous read into the output register; read bank is the one not being written.
  always_ff @(posedge clk) begin
    if (rst)        tri_out_q <= '0;
    else if (rd_en) tri_out_q <= mem[{~wr_bank_q, rd_idx_q[AW-1:0]}];
  end

  assign tri_out       = tri_out_q;
  assign tri_out_valid = tri_vld_q;
  assign replay_done   = rdone_q;

`ifdef TRIBUF_DROP_COUNT_EN
  logic        drop;
  logic [15:0] drop_cnt_q;
  // A triangle is lost when the bank is closed or already full.
  assign drop = triangle_valid & ((wst_q == W_CLOSED) | (wr_ptr_q == PW'(DEPTH)));

  // Saturating drop counter, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)                               drop_cnt_q <= '0;
    else if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
  end
  assign drop_count = drop_cnt_q;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_triangle_frame_buffer.sv
// Randomized bench for triangle_frame_buffer against a queue-based frame model.
module tb_triangle_frame_buffer;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] triangle = '0;
  logic         triangle_valid = 1'b0;
  logic         done_in = 1'b0;
  logic         new_frame = 1'b0;
  logic [127:0] tri_out;
  logic         tri_out_valid;
  logic         tri_out_ready = 1'b0;
  logic         replay_done;
  logic [15:0]  drop_count;

  always #5 clk = ~clk;

  triangle_frame_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .triangle(triangle), .triangle_valid(triangle_valid),
    .done_in(done_in), .new_frame(new_frame), .tri_out(tri_out),
    .tri_out_valid(tri_out_valid), .tri_out_ready(tri_out_ready),
    .replay_done(replay_done), .drop_count(drop_count)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: triangles gathered for the open bank, the last complete frame, drops.
  logic [127:0] wq[$];
  logic [127:0] frame[$];
  bit           m_has = 1'b0;
  bit           m_closed = 1'b0;
  int           m_drops = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [15:0] exp_drops();
`ifdef TRIBUF_DROP_COUNT_EN
    return (m_drops > 65535) ? 16'hFFFF : 16'(m_drops);
`else
    return 16'd0;
`endif
  endfunction

  task automatic note_tri(input logic [127:0] d);
    if (m_closed || wq.size() >= DEPTH) m_drops++;
    else wq.push_back(d);
  endtask

  task automatic m_swap();
    frame = wq;
    wq.delete();
    m_has = 1'b1;
    m_closed = 1'b0;
  endtask

  task automatic m_reset();
    wq.delete();
    frame.delete();
    m_has = 1'b0;
    m_closed = 1'b0;
    m_drops = 0;
  endtask

  task automatic send_tri(input logic [127:0] d);
    triangle = d;
    triangle_valid = 1'b1;
    note_tri(d);
    cyc();
    triangle_valid = 1'b0;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) send_tri(rnd128());
  endtask

  // Rising edge on done_in; optionally offer a triangle while closed and hold done high longer.
  task automatic close_bank(input bit overlap, input bit poke, input int extra_hi);
    done_in = 1'b1;
    cyc();
    m_closed = 1'b1;
    if (poke) begin
      triangle = rnd128();
      triangle_valid = 1'b1;
      note_tri(triangle);
    end
    if (extra_hi == 0) done_in = 1'b0;
    cyc();
    triangle_valid = 1'b0;
    if (!overlap) m_swap();
    repeat (extra_hi) cyc();
    done_in = 1'b0;
    chk("drop_count", drop_count, exp_drops());
  endtask

  // mode 0: ready held high; mode 1: random ready. hold_at stalls that index 5 cycles.
  task automatic replay(input int mode, input int hold_at);
    logic [127:0] exp[$];
    logic [127:0] held_v;
    int n, idx, cycles, stall;
    bit held, rdy;
    exp = frame;
    n = exp.size();
    new_frame = 1'b1;
    cyc();
    new_frame = 1'b0;
    if (!m_has) begin
      for (int i = 0; i < 4; i++) begin
        chk("noframe_valid", tri_out_valid, 0);
        chk("noframe_done", replay_done, 0);
        cyc();
      end
      return;
    end
    if (n == 0) begin
      chk("empty_done", replay_done, 1);
      chk("empty_valid", tri_out_valid, 0);
      cyc();
      chk("empty_done_pulse", replay_done, 0);
      chk("empty_valid2", tri_out_valid, 0);
      return;
    end
    chk("fetch_valid", tri_out_valid, 0);
    cyc();
    cycles = 1;
    chk("first_valid", tri_out_valid, 1);
    idx = 0; stall = 0; held = 1'b0; held_v = '0;
    while (idx < n && cycles < 400) begin
      chk("done_early", replay_done, 0);
      if (held) begin
        chk("hold_valid", tri_out_valid, 1);
        chk("hold_data", tri_out, held_v);
      end
      rdy = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (idx == hold_at && tri_out_valid && stall < 5) begin
        rdy = 1'b0;
        stall++;
      end
      tri_out_ready = rdy;
      held = tri_out_valid && !rdy;
      held_v = tri_out;
      if (tri_out_valid && rdy) begin
        chk($sformatf("data[%0d]", idx), tri_out, exp[idx]);
        idx++;
      end
      cyc();
      cycles++;
    end
    tri_out_ready = 1'b0;
    chk("replay_count", idx, n);
    if (mode == 0 && hold_at < 0) chk("throughput", cycles, 2 * n);
    chk("replay_done", replay_done, 1);
    chk("valid_after", tri_out_valid, 0);
    cyc();
    chk("replay_done_pulse", replay_done, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) cyc();
    rst = 1'b0;
    chk("rst_tri_out", tri_out, 0);
    chk("rst_valid", tri_out_valid, 0);
    chk("rst_done", replay_done, 0);
    chk("rst_drop", drop_count, 0);
    replay(0, -1);                    // nothing captured yet: ignored

    fill(3);                          // A, B, C
    close_bank(0, 0, 0);
    replay(0, -1);
    replay(0, 1);                     // same bank again, B stalled 5 cycles

    fill(6);                          // overflow: only first DEPTH kept
    close_bank(0, 0, 0);
    replay(0, -1);

    close_bank(0, 0, 0);              // empty pass
    replay(0, -1);

    fill(3);                          // overlap: frame 2 closes mid-replay
    close_bank(0, 0, 0);
    fork
      replay(1, 1);
      begin
        cyc();
        fill(2);
        close_bank(1, 0, 0);
      end
    join
    repeat (2) cyc();
    m_swap();
    replay(0, -1);
    replay(1, -1);

    for (int r = 0; r < 14; r++) begin
      fill($urandom_range(0, 6));
      close_bank(0, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      replay($urandom_range(0, 1), -1);
      if ($urandom_range(0, 2) == 0) replay(1, -1);
    end

    fill(2);                          // reset while presenting
    close_bank(0, 0, 0);
    new_frame = 1'b1;
    cyc();
    new_frame = 1'b0;
    tri_out_ready = 1'b0;
    cyc();
    chk("pre_rst_valid", tri_out_valid, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    m_reset();
    chk("midrst_valid", tri_out_valid, 0);
    chk("midrst_done", replay_done, 0);
    chk("midrst_tri_out", tri_out, 0);
    chk("midrst_drop", drop_count, 0);
    cyc();
    chk("midrst_done2", replay_done, 0);
    replay(0, -1);                    // no bank since reset: ignored
    fill(2);
    close_bank(0, 0, 0);
    replay(0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/triangle_frame_buffer.md
# triangle_frame_buffer

Consumer end of the projector's triangle stream. Captures the 128-bit triangles emitted during a projection pass into a write bank, closes the bank on the rising edge of the projector's level-held done signal, and replays the last complete bank to the rasterizer once per video frame through a valid/ready port. Ping-pong banks let projection of frame N+1 overlap rasterization of frame N.

## Interface
- DEPTH, 512, triangle slots per bank; power of two, ≥ 2
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- triangle  in  128  projected triangle word, stored opaquely
- triangle_valid  in  1  one-cycle strobe; triangle is captured this cycle
- done_in  in  1  projector done level; rising edge closes the write bank
- new_frame  in  1  one-cycle pulse from video timing requesting a replay
- tri_out  out  128  replayed triangle
- tri_out_valid  out  1  tri_out holds a triangle
- tri_out_ready  in  1  rasterizer accepts tri_out when high with valid
- replay_done  out  1  one-cycle pulse after the last triangle of a replay is accepted
- drop_count  out  16  triangles discarded since reset (see Configuration)

## Operation
- Storage: two banks of DEPTH × 128-bit, synchronous-read memory (1-cycle read latency). wr_bank/rd_bank select bit; wr_ptr and rd_len are $clog2(DEPTH)+1 bits.
- Write FSM: FILL, CLOSED.
  - FILL: on triangle_valid, if wr_ptr < DEPTH write at wr_ptr, wr_ptr += 1; else drop. On rising edge of done_in (done_in=1, previous sample=0) go CLOSED; a triangle_valid in the same cycle is stored first.
  - CLOSED: every triangle_valid dropped. When read FSM is IDLE: swap banks, rd_len ← wr_ptr, wr_ptr ← 0, has_frame ← 1, go FILL.
  - done_in held high past the swap produces no further close; a new rising edge is required.
- Read FSM: IDLE, FETCH, PRESENT.
  - IDLE: on new_frame with has_frame=1: rd_idx ← 0; if rd_len=0, pulse replay_done next cycle and stay IDLE; else go FETCH. new_frame with has_frame=0 is ignored.
  - FETCH: address rd_bank[rd_idx] issued; next cycle PRESENT with tri_out loaded, tri_out_valid=1.
  - PRESENT: hold tri_out and tri_out_valid until tri_out_ready. On acceptance: if rd_idx = rd_len−1, tri_out_valid ← 0, replay_done pulse, go IDLE; else rd_idx += 1, go FETCH.
  - new_frame outside IDLE is ignored (no queueing).
- Simultaneous swap and new_frame in IDLE: swap takes effect first; the replay uses the newly swapped bank.
- The same bank is replayed on every new_frame until a newer bank swaps in.

## Timing
- Reset values: tri_out=0, tri_out_valid=0, replay_done=0, drop_count=0; write FSM FILL, wr_ptr=0; read FSM IDLE; has_frame=0; wr_bank=0, rd_bank=1. Reset mid-replay aborts it with no replay_done pulse.
- new_frame at cycle t (IDLE) → FETCH at t+1 → tri_out_valid=1 at t+2.
- Replay throughput: one triangle per 2 cycles with tri_out_ready held high.
- Bank close to swap: 1 cycle when read FSM is IDLE; otherwise swap occurs on the cycle after read FSM returns to IDLE.
- replay_done is high exactly one cycle, the cycle after final acceptance.

## Configuration
- TRIBUF_DROP_COUNT_EN defined: drop_count increments on every dropped triangle (full bank or CLOSED), saturating at 16'hFFFF, cleared only by rst.
- Not defined: drop_count tied to 0 and the counter is not built. Drop behaviour is unchanged.

## Test plan
- Fill 3 triangles (A,B,C), raise done_in, pulse new_frame → tri_out A, B, C in order with ready=1, valid first seen 2 cycles after new_frame, replay_done pulsed once.
- Backpressure: hold tri_out_ready=0 for 5 cycles during B → B stable and valid throughout, C follows after acceptance.
- Overflow with DEPTH=4: send 6 triangles, close → replay yields first 4 only; drop_count=2 with TRIBUF_DROP_COUNT_EN, 0 without.
- Overlap: during replay of frame 1, fill and close frame 2 → swap delayed until replay_done; next new_frame replays frame 2; second new_frame before any further close replays frame 2 again.
- Empty pass: raise done_in with no triangles, new_frame → no tri_out_valid, replay_done 1 cycle after new_frame.
- Assert rst during PRESENT → tri_out_valid=0 next cycle, no replay_done; new_frame ignored until a new bank closes.
